// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single backing-memory port between the instruction cache (r0)
// and the data cache (r1). Requests are granted round-robin. A stalled grant
// is locked until it handshakes. An accepted write keeps the write-data
// channel for its owner until all WBEATS beats have been forwarded.
// Responses are steered back to a requester by the MSB of the memory tag.
module mem_port_arbiter #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int TAG_BITS  = 5,
   parameter int WBEATS    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   // requester 0 (instruction cache)
   input  logic                   r0_req_valid,
   output logic                   r0_req_ready,
   input  logic                   r0_req_rw,
   input  logic [ADDR_BITS-1:0]   r0_req_addr,
   input  logic [TAG_BITS-2:0]    r0_req_tag,
   input  logic                   r0_data_valid,
   output logic                   r0_data_ready,
   input  logic [DATA_BITS-1:0]   r0_data_bits,
   input  logic [DATA_BITS/8-1:0] r0_data_mask,
   output logic                   r0_resp_valid,
   output logic [TAG_BITS-2:0]    r0_resp_tag,
   output logic [DATA_BITS-1:0]   r0_resp_data,
   // requester 1 (data cache)
   input  logic                   r1_req_valid,
   output logic                   r1_req_ready,
   input  logic                   r1_req_rw,
   input  logic [ADDR_BITS-1:0]   r1_req_addr,
   input  logic [TAG_BITS-2:0]    r1_req_tag,
   input  logic                   r1_data_valid,
   output logic                   r1_data_ready,
   input  logic [DATA_BITS-1:0]   r1_data_bits,
   input  logic [DATA_BITS/8-1:0] r1_data_mask,
   output logic                   r1_resp_valid,
   output logic [TAG_BITS-2:0]    r1_resp_tag,
   output logic [DATA_BITS-1:0]   r1_resp_data,
   // backing memory
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic                   mem_req_rw,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic [TAG_BITS-1:0]    mem_req_tag,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_valid,
   input  logic [TAG_BITS-1:0]    mem_resp_tag,
   input  logic [DATA_BITS-1:0]   mem_resp_data
);

   localparam int MASK_BITS = DATA_BITS / 8;
   localparam int BEAT_BITS = $clog2(WBEATS + 1);
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WBEATS - 1);

   typedef enum logic {IDLE, WDATA} state_t;

   state_t               state;
   logic                 rr;        // requester with priority on the next contention
   logic                 lock;      // a grant is stalled on mem_req_ready
   logic                 lock_id;   // requester holding the stalled grant
   logic                 owner;     // requester owning the write-data channel
   logic [BEAT_BITS-1:0] beat;      // beats forwarded for the current write

   // Requester-side signals packed by requester index so the muxes index by id.
   logic [1:0]                 req_valid;
   logic [1:0]                 req_rw;
   logic [1:0][ADDR_BITS-1:0]  req_addr;
   logic [1:0][TAG_BITS-2:0]   req_tag;
   logic [1:0]                 data_valid;
   logic [1:0][DATA_BITS-1:0]  data_bits;
   logic [1:0][MASK_BITS-1:0]  data_mask;
   logic [1:0]                 req_ready;
   logic [1:0]                 data_ready;

   logic grant;
   logic req_fire;
   logic data_fire;
   logic resp_src;

   assign req_valid  = {r1_req_valid, r0_req_valid};
   assign req_rw     = {r1_req_rw, r0_req_rw};
   assign req_addr   = {r1_req_addr, r0_req_addr};
   assign req_tag    = {r1_req_tag, r0_req_tag};
   assign data_valid = {r1_data_valid, r0_data_valid};
   assign data_bits  = {r1_data_bits, r0_data_bits};
   assign data_mask  = {r1_data_mask, r0_data_mask};

   assign r0_req_ready  = req_ready[0];
   assign r1_req_ready  = req_ready[1];
   assign r0_data_ready = data_ready[0];
   assign r1_data_ready = data_ready[1];

   // Grant: a stalled grant sticks; otherwise the priority holder wins if it
   // is asking, else the other requester (only meaningful if it is valid).
   always_comb begin
      if (lock)
         grant = lock_id;
      else if (req_valid[rr])
         grant = rr;
      else
         grant = ~rr;
   end

   // Request channel: open only in IDLE and out of reset; the loser sees ready=0.
   always_comb begin
      mem_req_valid = 1'b0;
      req_ready     = '0;
      if (reset && state == IDLE) begin
         mem_req_valid    = req_valid[grant];
         req_ready[grant] = mem_req_ready;
      end
   end

   assign mem_req_rw   = req_rw[grant];
   assign mem_req_addr = req_addr[grant];
   assign mem_req_tag  = {grant, req_tag[grant]};

   // Write-data channel: open only to the owner while beats remain.
   always_comb begin
      mem_req_data_valid = 1'b0;
      data_ready         = '0;
      if (reset && state == WDATA) begin
         mem_req_data_valid = data_valid[owner];
         data_ready[owner]  = mem_req_data_ready;
      end
   end

   assign mem_req_data_bits = data_bits[owner];
   assign mem_req_data_mask = data_mask[owner];

   // Response steering: the tag MSB names the requester, the rest is its tag.
   assign resp_src      = mem_resp_tag[TAG_BITS-1];
   assign r0_resp_valid = reset && mem_resp_valid && !resp_src;
   assign r1_resp_valid = reset && mem_resp_valid && resp_src;
   assign r0_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
   assign r1_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
   assign r0_resp_data  = mem_resp_data;
   assign r1_resp_data  = mem_resp_data;

   assign req_fire  = mem_req_valid & mem_req_ready;
   assign data_fire = mem_req_data_valid & mem_req_data_ready;

   // Control FSM: grant lock, round-robin pointer, write ownership, beat count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         rr      <= 1'b0;
         lock    <= 1'b0;
         lock_id <= 1'b0;
         owner   <= 1'b0;
         beat    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  lock <= 1'b0;
                  rr   <= ~grant;
                  if (mem_req_rw) begin
                     state <= WDATA;
                     owner <= grant;
                     beat  <= '0;
                  end
               end else if (mem_req_valid) begin
                  lock    <= 1'b1;
                  lock_id <= grant;
               end
            end
            WDATA: begin
               if (data_fire) begin
                  if (beat == LAST_BEAT) begin
                     state <= IDLE;
                     beat  <= '0;
                  end else begin
                     beat <= beat + BEAT_BITS'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios first, then random traffic from two requester drivers
// plus a random memory. Drivers push expected memory-side requests/beats at
// their own handshakes; the responder pushes expected routed responses; a
// monitor pops and compares whenever the DUT presents memory-side or response
// traffic, and checks the grant/lock/ownership rules against a small model.
module tb_mem_port_arbiter;
   localparam int AB = 28, DB = 128, TB = 5, WB = 4, MB = DB / 8;
   localparam int NTX = 30;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // requester stimulus, indexed by requester id
   logic          rv[2], rrw[2], dv[2];
   logic [AB-1:0] raddr[2];
   logic [TB-2:0] rtag[2];
   logic [DB-1:0] dbits[2];
   logic [MB-1:0] dmask[2];
   logic          done[2];

   logic          r0_req_ready, r1_req_ready, r0_data_ready, r1_data_ready;
   logic          r0_resp_valid, r1_resp_valid;
   logic [TB-2:0] r0_resp_tag, r1_resp_tag;
   logic [DB-1:0] r0_resp_data, r1_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [AB-1:0] mem_req_addr;
   logic [TB-1:0] mem_req_tag;
   logic          mem_req_data_valid, mem_req_data_ready;
   logic [DB-1:0] mem_req_data_bits;
   logic [MB-1:0] mem_req_data_mask;
   logic          mem_resp_valid;
   logic [TB-1:0] mem_resp_tag;
   logic [DB-1:0] mem_resp_data;

   logic rrdy[2], drdy[2];
   assign rrdy[0] = r0_req_ready;
   assign rrdy[1] = r1_req_ready;
   assign drdy[0] = r0_data_ready;
   assign drdy[1] = r1_data_ready;

   mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .WBEATS(WB)) dut (
      .clk(clk), .reset(reset),
      .r0_req_valid(rv[0]), .r0_req_ready(r0_req_ready), .r0_req_rw(rrw[0]),
      .r0_req_addr(raddr[0]), .r0_req_tag(rtag[0]),
      .r0_data_valid(dv[0]), .r0_data_ready(r0_data_ready),
      .r0_data_bits(dbits[0]), .r0_data_mask(dmask[0]),
      .r0_resp_valid(r0_resp_valid), .r0_resp_tag(r0_resp_tag), .r0_resp_data(r0_resp_data),
      .r1_req_valid(rv[1]), .r1_req_ready(r1_req_ready), .r1_req_rw(rrw[1]),
      .r1_req_addr(raddr[1]), .r1_req_tag(rtag[1]),
      .r1_data_valid(dv[1]), .r1_data_ready(r1_data_ready),
      .r1_data_bits(dbits[1]), .r1_data_mask(dmask[1]),
      .r1_resp_valid(r1_resp_valid), .r1_resp_tag(r1_resp_tag), .r1_resp_data(r1_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard queues
   logic [TB+AB:0]   exp_req[$];    // {tag, addr, rw}
   logic [MB+DB-1:0] exp_beat[$];   // {mask, bits}
   logic [TB+DB-1:0] exp_resp[$];   // {tag, data}

   // monitor model: who was granted last, outstanding beats, stalled request
   logic             mon_en = 1'b0;
   logic             m_last, m_stall, m_owner, exp_src;
   int               m_owed;
   logic [TB+AB:0]   m_held;
   logic [TB+DB-1:0] e_resp;
   logic [MB+DB-1:0] e_beat;

   // Monitor: compare DUT-presented traffic against queued expectations and rules.
   always @(negedge clk) begin
      #1;
      if (!mon_en || !reset) begin
         m_last = 1'b1; m_owed = 0; m_stall = 1'b0; m_owner = 1'b0;
      end else begin
         if (r0_resp_valid || r1_resp_valid) begin
            if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
               e_resp = exp_resp.pop_front();
               chk("resp_valid", {r1_resp_valid, r0_resp_valid},
                   e_resp[TB+DB-1] ? 2'b10 : 2'b01);
               chk("resp_tag", e_resp[TB+DB-1] ? r1_resp_tag : r0_resp_tag, e_resp[TB+DB-2:DB]);
               chk("resp_data", e_resp[TB+DB-1] ? r1_resp_data : r0_resp_data, e_resp[DB-1:0]);
            end
         end
         if (m_owed == 0) begin
            chk("idle_data", {mem_req_data_valid, r1_data_ready, r0_data_ready}, 0);
            if (m_stall)
               chk("lock_hold", {mem_req_valid, mem_req_tag, mem_req_addr, mem_req_rw}, {1'b1, m_held});
            else if (rv[0] || rv[1]) begin
               exp_src = (rv[0] && rv[1]) ? ~m_last : rv[1];
               chk("grant", {mem_req_valid, mem_req_tag[TB-1]}, {1'b1, exp_src});
            end else
               chk("no_req", mem_req_valid, 0);
            if (mem_req_valid && mem_req_ready) begin
               if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
               else chk("req_fwd", {mem_req_tag, mem_req_addr, mem_req_rw}, exp_req.pop_front());
               m_last  = mem_req_tag[TB-1];
               m_stall = 1'b0;
               if (mem_req_rw) begin
                  m_owed  = WB;
                  m_owner = mem_req_tag[TB-1];
               end
            end else if (mem_req_valid) begin
               m_stall = 1'b1;
               m_held  = {mem_req_tag, mem_req_addr, mem_req_rw};
            end
         end else begin
            chk("wdata_no_req", {mem_req_valid, r1_req_ready, r0_req_ready}, 0);
            chk("wdata_valid", mem_req_data_valid, dv[m_owner]);
            chk("non_owner_ready", m_owner ? r0_data_ready : r1_data_ready, 0);
            if (mem_req_data_valid && mem_req_data_ready) begin
               if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
               else begin
                  e_beat = exp_beat.pop_front();
                  chk("beat_bits", mem_req_data_bits, e_beat[DB-1:0]);
                  chk("beat_mask", mem_req_data_mask, e_beat[MB+DB-1:DB]);
               end
               m_owed--;
            end
         end
      end
   end

   // Random requester: hold a request until accepted, then stream beats for writes.
   task automatic req_drive(input int n);
      int w;
      for (int i = 0; i < NTX; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         rrw[n]   = ($urandom % 2) == 1;
         raddr[n] = AB'($urandom);
         rtag[n]  = (TB-1)'($urandom);
         rv[n]    = 1'b1;
         w = 0;
         forever begin
            @(negedge clk);
            if (rrdy[n]) begin
               exp_req.push_back({1'(n), rtag[n], raddr[n], rrw[n]});
               break;
            end
            if (++w > 500) begin chk("req_timeout", 1, 0); break; end
            @(posedge clk); #1;
         end
         tick();
         rv[n] = 1'b0;
         if (rrw[n] && w <= 500) begin
            for (int b = 0; b < WB; b++) begin
               w = 0;
               forever begin
                  dv[n]    = ($urandom % 4) != 0;
                  dbits[n] = {$urandom, $urandom, $urandom, $urandom};
                  dmask[n] = MB'($urandom);
                  @(negedge clk);
                  if (dv[n] && drdy[n]) begin
                     exp_beat.push_back({dmask[n], dbits[n]});
                     tick();
                     break;
                  end
                  tick();
                  if (++w > 500) begin chk("beat_timeout", 1, 0); break; end
               end
            end
            dv[n] = 1'b0;
         end
      end
      done[n] = 1'b1;
   endtask

   // Random memory: backpressure on both channels and unsolicited responses.
   task automatic mem_drive();
      while (!(done[0] && done[1])) begin
         mem_req_ready      = ($urandom % 4) != 0;
         mem_req_data_ready = ($urandom % 3) != 0;
         mem_resp_valid     = ($urandom % 3) == 0;
         mem_resp_tag       = TB'($urandom);
         mem_resp_data      = {$urandom, $urandom, $urandom, $urandom};
         if (mem_resp_valid) exp_resp.push_back({mem_resp_tag, mem_resp_data});
         tick();
      end
      mem_resp_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   logic [DB-1:0] dd;
   initial begin
      for (int i = 0; i < 2; i++) begin
         rv[i] = 0; rrw[i] = 0; dv[i] = 0; raddr[i] = '0; rtag[i] = '0;
         dbits[i] = '0; dmask[i] = '0; done[i] = 0;
      end
      mem_req_ready = 1; mem_req_data_ready = 1;
      mem_resp_valid = 1; mem_resp_tag = '0; mem_resp_data = '0;
      rv[0] = 1; dv[0] = 1;
      tick(); tick();
      // reset forces every valid/ready output low
      @(negedge clk);
      chk("reset_outputs", {mem_req_valid, mem_req_data_valid, r0_req_ready, r1_req_ready,
                            r0_data_ready, r1_data_ready, r0_resp_valid, r1_resp_valid}, 0);
      // single r0 read, zero-latency forward
      tick();
      reset = 1; dv[0] = 0; mem_resp_valid = 0;
      raddr[0] = 28'h0001234; rtag[0] = 4'd3; rrw[0] = 0;
      @(negedge clk);
      chk("rd_fwd", {mem_req_valid, mem_req_rw, mem_req_tag, mem_req_addr}, {2'b10, 5'h03, 28'h0001234});
      chk("rd_ready", {r1_req_ready, r0_req_ready}, 2'b01);
      tick();
      rv[0] = 0;
      dd = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
      mem_resp_valid = 1; mem_resp_tag = 5'h03; mem_resp_data = dd;
      @(negedge clk);
      chk("rd_resp", {r1_resp_valid, r0_resp_valid, r0_resp_tag}, {2'b01, 4'd3});
      chk("rd_resp_data", r0_resp_data, dd);
      tick();
      mem_resp_valid = 0;
      // continuous contention alternates r0, r1, r0, r1 after reset
      reset = 0;
      tick();
      reset = 1; rv[0] = 1; rv[1] = 1; rrw[1] = 0; rtag[1] = 4'd7;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("alternate", {mem_req_valid, mem_req_tag[TB-1]}, {1'b1, 1'(k % 2)});
         tick();
      end
      rv[0] = 0; rv[1] = 0;
      // one r0 grant so priority points at r1, then stall r0 with r1 arriving
      rv[0] = 1;
      tick();
      rv[0] = 0; mem_req_ready = 0;
      rv[0] = 1; raddr[0] = 28'hAAAA; rtag[0] = 4'd4;
      @(negedge clk);
      chk("stall_c1", {mem_req_tag, mem_req_addr}, {5'h04, 28'hAAAA});
      tick();
      rv[1] = 1; raddr[1] = 28'hBBBB; rtag[1] = 4'd5;
      @(negedge clk);
      chk("stall_c2", {mem_req_tag, mem_req_addr}, {5'h04, 28'hAAAA});
      tick();
      @(negedge clk);
      chk("stall_c3", {mem_req_tag, mem_req_addr, r1_req_ready}, {5'h04, 28'hAAAA, 1'b0});
      tick();
      mem_req_ready = 1;
      @(negedge clk);
      chk("stall_release", {r1_req_ready, r0_req_ready, mem_req_addr}, {2'b01, 28'hAAAA});
      tick();
      rv[0] = 0;
      @(negedge clk);
      chk("stall_next_r1", {r1_req_ready, mem_req_tag, mem_req_addr}, {1'b1, 5'h15, 28'hBBBB});
      tick();
      rv[1] = 0;
      // reset during r0 write after two beats aborts the write
      rv[0] = 1; rrw[0] = 1; raddr[0] = 28'h40; rtag[0] = 4'd2;
      @(negedge clk);
      chk("wr_req", {mem_req_rw, mem_req_tag, mem_req_addr}, {1'b1, 5'h02, 28'h40});
      tick();
      rv[0] = 0; rrw[0] = 0; dv[0] = 1; dmask[0] = 16'hF0F0;
      for (int b = 0; b < 2; b++) begin
         dbits[0] = DB'(b + 100);
         @(negedge clk);
         chk("wr_beat", {mem_req_data_valid, r0_data_ready, mem_req_data_mask, mem_req_data_bits},
             {2'b11, 16'hF0F0, DB'(b + 100)});
         tick();
      end
      reset = 0;
      @(negedge clk);
      chk("rst_mid_write", {mem_req_valid, mem_req_data_valid, r0_req_ready, r1_req_ready,
                            r0_data_ready, r1_data_ready}, 0);
      tick();
      reset = 1; rv[0] = 1; rv[1] = 1;
      @(negedge clk);
      chk("post_rst_idle", {mem_req_data_valid, r0_data_ready}, 0);
      chk("post_rst_grant", {mem_req_valid, mem_req_tag[TB-1], r0_req_ready}, 3'b101);
      tick();
      rv[0] = 0; dv[0] = 0;
      @(negedge clk);
      chk("post_rst_r1", {r1_req_ready, mem_req_tag[TB-1]}, 2'b11);
      tick();
      rv[1] = 0;
      // response routed to r1 while r0 owns the write-data channel
      rv[0] = 1; rrw[0] = 1; raddr[0] = 28'h80; rtag[0] = 4'd1;
      tick();
      rv[0] = 0; rrw[0] = 0;
      for (int b = 0; b < WB; b++) begin
         dv[0] = 1; dbits[0] = DB'(b + 200);
         mem_resp_valid = (b == 0); mem_resp_tag = 5'h1F; mem_resp_data = dd;
         @(negedge clk);
         if (b == 0)
            chk("resp_in_wdata", {r1_resp_valid, r0_resp_valid, r1_resp_tag}, {2'b10, 4'hF});
         chk("wdata_beat", {mem_req_data_valid, mem_req_data_bits}, {1'b1, DB'(b + 200)});
         tick();
      end
      dv[0] = 0; mem_resp_valid = 0;
      @(negedge clk);
      chk("wdata_done", {mem_req_data_valid, r0_data_ready}, 0);
      tick();
      // random phase
      reset = 0;
      tick();
      reset = 1; mon_en = 1;
      fork
         req_drive(0);
         req_drive(1);
         mem_drive();
      join
      tick(); tick();
      mon_en = 0;
      chk("req_q_empty", 128'(exp_req.size()), 0);
      chk("beat_q_empty", 128'(exp_beat.size()), 0);
      chk("resp_q_empty", 128'(exp_resp.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
